// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: stall arbitration, MEM-stage exception take, CP0 commit strobe and held fetch redirect.
// Optional macro HFC_PERF_CNT_EN adds stall-cycle and flush performance counters.
module hazard_flush_ctrl #(
  parameter logic [4:0]  EXC_NONE  = 5'h10,
  parameter logic [4:0]  EXC_ERET  = 5'h11,
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        stallreq_mem,
  input  logic [4:0]  mem_exccode,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay,
  input  logic [31:0] cp0_epc,
  input  logic        if_accept,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        exc_we,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc
`ifdef HFC_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state, state_nxt;
  logic        exc_take;
  logic        is_eret;
  logic [31:0] redirect_pc_nxt;

  assign is_eret      = (mem_exccode == EXC_ERET);
  assign exc_take     = (state == IDLE) && (mem_exccode != EXC_NONE) && !stallreq_mem;
  assign redirect_vld = (state == REDIR);

  // An exception being taken flushes everything, so it overrides any lower-stage stall.
  always_comb begin
    stall           = 6'b000000;
    flush           = 1'b0;
    exc_we          = 1'b0;
    exc_code        = 5'd0;
    exc_epc         = 32'd0;
    exc_bd          = 1'b0;
    state_nxt       = state;
    redirect_pc_nxt = redirect_pc;

    if (exc_take) begin
      flush           = 1'b1;
      state_nxt       = REDIR;
      redirect_pc_nxt = is_eret ? cp0_epc : EXC_ENTRY;
      if (!is_eret) begin
        exc_we   = 1'b1;
        exc_code = mem_exccode;
        exc_epc  = mem_in_delay ? (mem_pc - 32'd4) : mem_pc;
        exc_bd   = mem_in_delay;
      end
    end else begin
      if (stallreq_mem)      stall = 6'b011111;
      else if (stallreq_exe) stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
      else if (stallreq_if)  stall = 6'b000011;

      if (state == REDIR && if_accept) state_nxt = IDLE;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state       <= IDLE;
      redirect_pc <= 32'd0;
    end else begin
      state       <= state_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

`ifdef HFC_PERF_CNT_EN
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall[0]) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (flush)    perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
